// File: rtl/viterbi_pkg.sv
// Shared types, constants and branch-metric helper for the Viterbi decoder.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACS,
    TRACE,
    DONE
  } state_e;

  localparam int unsigned PM_W      = 10;
  localparam int unsigned PM_INIT   = 256;
  localparam int unsigned MAX_FRAME = 256;

  // Hamming distance between an expected and a received 2-bit symbol.
  function automatic logic [1:0] branch_metric(input logic [1:0] expected,
                                               input logic [1:0] received);
    logic [1:0] diff;
    diff = expected ^ received;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to predecessor p0.
module viterbi_acs
  import viterbi_pkg::*;
(
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  // Pick p1 only when its candidate metric is strictly smaller.
  always_comb begin
    cand0 = pm0_i + PM_W'(bm0_i);
    cand1 = pm1_i + PM_W'(bm1_i);
    dec_o = (cand1 < cand0);
    pm_o  = dec_o ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_universal_decoder.sv
// Frame-level hard-decision rate-1/2 Viterbi decoder, parameterised K/G0/G1.
// Optional build macro VITERBI_ZERO_TERM_EN: traceback always starts at state 0.
module viterbi_universal_decoder
  import viterbi_pkg::*;
#(
  parameter int unsigned    K  = 7,
  parameter logic [K-1:0]   G0 = 7'b1111001,
  parameter logic [K-1:0]   G1 = 7'b1011011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [1:0] syms_in [MAX_FRAME],
  output logic       done,
  output logic [7:0] out_len,
  output logic       bits_out [MAX_FRAME]
);

  localparam int unsigned SW = K - 1;
  localparam int unsigned NS = 1 << SW;

  state_e            state_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic              first_q;
  logic [SW-1:0]     tr_q;
  logic              done_q;
  logic [7:0]        out_len_q;
  logic [PM_W-1:0]   pm_q    [NS];
  logic [PM_W-1:0]   pm_new  [NS];
  logic [NS-1:0]     dec_new;
  logic [NS-1:0]     dec_q   [MAX_FRAME];
  logic              bits_q  [MAX_FRAME];
  logic [1:0]        sym_cur;
  logic [SW-1:0]     start_state;

  function automatic logic [PM_W-1:0] pm_init(input int unsigned idx);
    return (idx == 0) ? '0 : PM_W'(PM_INIT);
  endfunction

  assign sym_cur = syms_in[cnt_q];

  // State s is reached from {x, s[K-2:1]} with input s[0], so the encoder
  // register for that branch is simply {x, s}; expected symbols are constants.
  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam logic [K-1:0]   R0 = {1'b0, SW'(s)};
    localparam logic [K-1:0]   R1 = {1'b1, SW'(s)};
    localparam logic [1:0]     E0 = {^(R0 & G0), ^(R0 & G1)};
    localparam logic [1:0]     E1 = {^(R1 & G0), ^(R1 & G1)};
    localparam int unsigned    P0 = s >> 1;
    localparam int unsigned    P1 = P0 + NS / 2;

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = branch_metric(E0, sym_cur);
    assign bm1 = branch_metric(E1, sym_cur);

    viterbi_acs u_acs (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (pm_new[s]),
      .dec_o (dec_new[s])
    );
  end

`ifdef VITERBI_ZERO_TERM_EN
  assign start_state = '0;
`else
  logic [PM_W-1:0] best_pm;

  // Lowest-index state holding the minimum final path metric.
  always_comb begin
    best_pm     = pm_q[0];
    start_state = '0;
    for (int unsigned i = 1; i < NS; i++) begin
      if (pm_q[i] < best_pm) begin
        best_pm     = pm_q[i];
        start_state = SW'(i);
      end
    end
  end
`endif

  // Survivor memory: one decision word per trellis step.
  always_ff @(posedge clk) begin
    if (state_q == ACS && len_q != '0) begin
      dec_q[cnt_q] <= dec_new;
    end
  end

  // Control FSM, path metrics, traceback and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      tr_q      <= '0;
      done_q    <= 1'b0;
      out_len_q <= '0;
      for (int unsigned i = 0; i < MAX_FRAME; i++) bits_q[i] <= 1'b0;
      for (int unsigned i = 0; i < NS; i++) pm_q[i] <= pm_init(i);
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= ACS;
            len_q   <= frame_len;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < MAX_FRAME; i++) bits_q[i] <= 1'b0;
            for (int unsigned i = 0; i < NS; i++) pm_q[i] <= pm_init(i);
          end
        end
        ACS: begin
          if (len_q == '0) begin
            state_q <= TRACE;
            first_q <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < NS; i++) pm_q[i] <= pm_new[i];
            // cnt_q is left at len-1, which is the first traceback index.
            if (cnt_q == len_q - 8'd1) begin
              state_q <= TRACE;
              first_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        TRACE: begin
          // The first TRACE cycle only registers the start state, so the
          // minimum search is never chained into the survivor-memory read.
          if (first_q) begin
            first_q <= 1'b0;
            tr_q    <= start_state;
            if (len_q == '0) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              out_len_q <= len_q;
            end
          end else begin
            bits_q[cnt_q] <= tr_q[0];
            tr_q          <= {dec_q[cnt_q][tr_q], tr_q[SW-1:1]};
            if (cnt_q == '0) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              out_len_q <= len_q;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done     = done_q;
  assign out_len  = out_len_q;
  assign bits_out = bits_q;

endmodule

// File: tb/tb_viterbi_universal_decoder.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks on done.
module tb_viterbi_universal_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start7, start6;
  logic [7:0] len7, len6;
  logic [1:0] syms7 [256];
  logic [1:0] syms6 [256];
  logic       done7, done6;
  logic [7:0] olen7, olen6;
  logic       bits7 [256];
  logic       bits6 [256];

  viterbi_universal_decoder #(.K(7), .G0(7'b1111001), .G1(7'b1011011)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .frame_len(len7), .syms_in(syms7),
    .done(done7), .out_len(olen7), .bits_out(bits7)
  );

  viterbi_universal_decoder #(.K(6), .G0(6'b111111), .G1(6'b101011)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .frame_len(len6), .syms_in(syms6),
    .done(done6), .out_len(olen6), .bits_out(bits6)
  );

  typedef struct {
    logic [255:0] bits;
    logic [7:0]   len;
    int           done_cyc;
  } exp_t;

  exp_t q7[$];
  exp_t q6[$];
  exp_t e7, e6;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic p7 = 1'b0;
  logic p6 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [255:0] pack(input logic b [256]);
    logic [255:0] v;
    for (int i = 0; i < 256; i++) v[i] = b[i];
    return v;
  endfunction

  // Reference convolutional encoder written as a shift register.
  function automatic logic [511:0] encode(input int k, input logic [6:0] g0, input logic [6:0] g1,
                                          input logic [255:0] b, input int len);
    logic [511:0] v;
    logic [6:0]   st, r, mask;
    v    = '0;
    st   = '0;
    mask = 7'((1 << k) - 1);
    for (int t = 0; t < len; t++) begin
      r          = ((st << 1) | {6'd0, b[t]}) & mask;
      v[2*t+1]   = ^(r & g0);
      v[2*t]     = ^(r & g1);
      st         = r & (mask >> 1);
    end
    return v;
  endfunction

  // Monitor: on each rising done, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (done7 && !p7) begin
      if (q7.size() == 0) begin
        checks++;
        $display("FAIL done7_unexpected: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        e7 = q7.pop_front();
        check("latency7", 256'(cyc), 256'(e7.done_cyc));
        check("out_len7", 256'(olen7), 256'(e7.len));
        check("bits7", pack(bits7), e7.bits);
      end
    end
    p7 = done7;
    if (done6 && !p6) begin
      if (q6.size() == 0) begin
        checks++;
        $display("FAIL done6_unexpected: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        e6 = q6.pop_front();
        check("latency6", 256'(cyc), 256'(e6.done_cyc));
        check("out_len6", 256'(olen6), 256'(e6.len));
        check("bits6", pack(bits6), e6.bits);
      end
    end
    p6 = done6;
  end

  task automatic load7(input logic [511:0] v);
    for (int i = 0; i < 256; i++) syms7[i] = v[2*i +: 2];
  endtask

  task automatic load6(input logic [511:0] v);
    for (int i = 0; i < 256; i++) syms6[i] = v[2*i +: 2];
  endtask

  task automatic go7(input int len, input logic [255:0] expbits);
    exp_t e;
    @(negedge clk);
    start7     = 1'b1;
    len7       = 8'(len);
    e.bits     = expbits;
    e.len      = 8'(len);
    e.done_cyc = cyc + 1 + ((len == 0) ? 2 : 2 * len + 1);
    q7.push_back(e);
    @(negedge clk);
    start7 = 1'b0;
  endtask

  task automatic go6(input int len, input logic [255:0] expbits);
    exp_t e;
    @(negedge clk);
    start6     = 1'b1;
    len6       = 8'(len);
    e.bits     = expbits;
    e.len      = 8'(len);
    e.done_cyc = cyc + 1 + ((len == 0) ? 2 : 2 * len + 1);
    q6.push_back(e);
    @(negedge clk);
    start6 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && (q7.size() != 0 || q6.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    if (q7.size() != 0 || q6.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q7.size(), q6.size());
      q7.delete();
      q6.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [511:0] v;
  logic [255:0] expb;

  initial begin
    rst    = 1'b1;
    start7 = 1'b0;
    start6 = 1'b0;
    len7   = '0;
    len6   = '0;
    load7('0);
    load6('0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_done7", 256'(done7), 256'(0));
    check("rst_len7", 256'(olen7), 256'(0));
    check("rst_bits7", pack(bits7), '0);
    check("rst_done6", 256'(done6), 256'(0));
    check("rst_len6", 256'(olen6), 256'(0));
    check("rst_bits6", pack(bits6), '0);

    // K=6 impulse at bit 16.
    expb = 256'd1 << 16;
    load6(encode(6, 7'b0111111, 7'b0101011, expb, 32));
    go6(32, expb);
    wait_drain();

    // K=7 impulse at bit 20.
    expb = 256'd1 << 20;
    load7(encode(7, 7'b1111001, 7'b1011011, expb, 32));
    go7(32, expb);
    wait_drain();

    // K=7 all-zero frame with one symbol bit flipped at t=10.
    v = encode(7, 7'b1111001, 7'b1011011, '0, 32);
    v[21] = ~v[21];
    load7(v);
    go7(32, '0);
    wait_drain();

    // Empty frame.
    go7(0, '0);
    wait_drain();

    // K=6 maximum-length frame with a dense pattern.
    expb = {4{64'hA5C3_0FF1_9E27_6B4D}};
    expb[255] = 1'b0;
    load6(encode(6, 7'b0111111, 7'b0101011, expb, 255));
    go6(255, expb);
    wait_drain();

    // Extra start pulse during ACS must be ignored.
    expb = 256'd1 << 20;
    load7(encode(7, 7'b1111001, 7'b1011011, expb, 32));
    go7(32, expb);
    repeat (5) @(negedge clk);
    start7 = 1'b1;
    len7   = 8'd5;
    @(negedge clk);
    start7 = 1'b0;
    wait_drain();

    // Reset during TRACE, after bit 20 has been written back.
    @(negedge clk);
    start7 = 1'b1;
    len7   = 8'd32;
    @(negedge clk);
    start7 = 1'b0;
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_done7", 256'(done7), 256'(0));
    check("midrst_len7", 256'(olen7), 256'(0));
    check("midrst_bits7", pack(bits7), '0);

    // Fresh decode after the abort.
    expb = 256'd1 << 3;
    load7(encode(7, 7'b1111001, 7'b1011011, expb, 40));
    go7(40, expb);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/viterbi_universal_decoder.md
# viterbi_universal_decoder

Hard-decision, rate-1/2 Viterbi decoder with the constraint length and generator polynomials set by parameters. It decodes one buffered frame of up to 256 two-bit symbols per `start` request into a buffered bit array. It is the frame-level decode block behind the channel-symbol buffer, and is synthesizable for K = 3..7.

## Interface
- `K`, 7: constraint length; 2^(K-1) trellis states.
- `G0`, 7'b1111001: K-bit generator for symbol bit [1]; the MSB taps the oldest bit.
- `G1`, 7'b1011011: K-bit generator for symbol bit [0].
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  single-cycle decode request.
- `frame_len`  in  8  number of symbols to decode, 0..255; sampled at start.
- `syms_in`  in  [1:0] x 256 unpacked  received symbols; `syms_in[t] = {G0 parity, G1 parity}`; must stay stable while busy.
- `done`  out  1  decode complete (level).
- `out_len`  out  8  number of valid decoded bits.
- `bits_out`  out  1 x 256 unpacked  decoded bits; `bits_out[t]` is the input bit of step t.

## Operation
- Encoder model:
  - Start state is 0.
  - At step t with input b, form `r = {state[K-2:0], b}`.
  - Output symbol is `{^(r&G0), ^(r&G1)}`.
  - Next state is `r[K-2:0]`.
- Path metrics:
  - 10-bit unsigned.
  - At start: PM[0]=0; all other states 256.
  - No normalization is needed, since the maximum is 766.
- Branch metric: Hamming distance (0..2) between the expected symbol and `syms_in[t]`.
- ACS for each next state s:
  - Predecessors are p0 = {0, s[K-2:1]} and p1 = {1, s[K-2:1]}; the input bit is s[0].
  - Select p1 only if its candidate metric is strictly smaller; ties go to p0.
  - Store the decision bit dec[t][s].
- All states are updated in parallel, one trellis step per cycle.
- Traceback:
  - Start at the state with the minimum final PM; ties go to the lowest index.
  - For t = frame_len-1 down to 0: `bits_out[t] = s[0]`, then `s = {dec[t][s], s[K-2:1]}`.
- No tail bits are required. Frames need not be zero-terminated.
- `out_len` is set to `frame_len` at completion.
- FSM:
  - IDLE -> ACS on `start`.
  - ACS runs frame_len cycles -> TRACE.
  - TRACE runs frame_len cycles -> DONE.
  - DONE -> ACS on `start`.
  - If frame_len=0: ACS -> TRACE -> DONE with no bit writes.
- `start` is ignored in ACS and TRACE.
- At `start`, `bits_out` is cleared to 0 and `done` drops.

## Timing
- Reset values: `done`=0, `out_len`=0, all `bits_out`=0, FSM=IDLE, PMs at their initial values.
- Reset has priority over everything, including mid-decode; it aborts with no output.
- Start accepted at edge N: ACS occupies N+1..N+L, TRACE occupies N+L+1..N+2L, and `done`=1 from edge N+2L+1.
  - L is frame_len. With L=0, `done` rises at N+2.
- `done` stays high until the next accepted `start` or reset.
- `bits_out` and `out_len` are stable while `done`=1.

## Configuration
- `VITERBI_ZERO_TERM_EN` defined: traceback always starts from state 0. Use this for zero-flushed frames; it removes the minimum-search logic.
- Undefined (default): traceback starts from the minimum-PM state as above.

## Structure
- Package `viterbi_pkg`:
  - FSM state enum (IDLE, ACS, TRACE, DONE).
  - `PM_W`=10, `PM_INIT`=256, `MAX_FRAME`=256.
  - Branch-metric function: popcount of a 2-bit XOR.
- Sub-module `viterbi_acs`: one per state, generated 2^(K-1) times.
  - Inputs: two PMs and two branch metrics.
  - Outputs: new PM and decision bit.
- The top module holds the FSM, the survivor memory (256 x 2^(K-1) bits), and traceback.

## Test plan
- K=6, G0=6'b111111, G1=6'b101011, 32 symbols encoding a single '1' at bit 16 -> `done` within 300 cycles; `bits_out[16]`=1, bits 0..31 otherwise 0; `out_len`=32.
- K=7 default generators, 32 symbols with a single '1' at bit 20 -> only `bits_out[20]`=1 in 0..31; `done` at cycle 2*32+1 after start.
- K=7, all-zero input with one symbol bit flipped at t=10 -> all 32 output bits 0 (error corrected).
- frame_len=0 -> `done` two cycles after start; `out_len`=0; `bits_out` all 0.
- Pulse `start` again during ACS -> ignored, same timing and result. Assert `rst` mid-TRACE -> `done`=0, outputs cleared; a new start then decodes correctly.
